// File: rtl/pwm_fade_engine.sv
// Three-channel duty-cycle ramp generator feeding a 3-channel PWM controller.
// Optional sticky completion interrupt enabled by defining PWM_FADE_IRQ_EN.
module pwm_fade_engine #(
    parameter int unsigned INTERVAL_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fade_enable,
    input  logic                  period_complete,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic                  ch0_load,
    input  logic [7:0]            ch0_target,
    input  logic [7:0]            ch0_step,
    input  logic                  ch1_load,
    input  logic [7:0]            ch1_target,
    input  logic [7:0]            ch1_step,
    input  logic                  ch2_load,
    input  logic [7:0]            ch2_target,
    input  logic [7:0]            ch2_step,
    output logic [7:0]            ch0_duty_cycle,
    output logic [7:0]            ch1_duty_cycle,
    output logic [7:0]            ch2_duty_cycle,
    output logic                  ch0_busy,
    output logic                  ch1_busy,
    output logic                  ch2_busy,
    output logic                  ch0_done,
    output logic                  ch1_done,
    output logic                  ch2_done,
    output logic                  irq,
    input  logic                  irq_clear
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    logic [INTERVAL_W-1:0] tick_cnt;
    logic [INTERVAL_W-1:0] interval_eff;
    logic [INTERVAL_W:0]   tick_next;
    logic                  step_strobe;

    logic [2:0] load;
    logic [7:0] target_in [3];
    logic [7:0] step_in   [3];

    state_t     state  [3];
    logic [7:0] duty   [3];
    logic [7:0] target [3];
    logic [7:0] step   [3];
    logic [8:0] sum_up [3];
    logic [8:0] diff_dn[3];
    logic [2:0] busy_r;
    logic [2:0] done_r;

    assign load      = {ch2_load, ch1_load, ch0_load};
    assign target_in = '{ch0_target, ch1_target, ch2_target};
    assign step_in   = '{ch0_step, ch1_step, ch2_step};

    always_comb begin
        interval_eff = (interval == '0) ? INTERVAL_W'(1) : interval;
        tick_next    = {1'b0, tick_cnt} + (INTERVAL_W + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt    <= '0;
            step_strobe <= 1'b0;
        end else if (!fade_enable) begin
            tick_cnt    <= '0;
            step_strobe <= 1'b0;
        end else if (period_complete) begin
            if (tick_next >= {1'b0, interval_eff}) begin
                tick_cnt    <= '0;
                step_strobe <= 1'b1;
            end else begin
                tick_cnt    <= tick_next[INTERVAL_W-1:0];
                step_strobe <= 1'b0;
            end
        end else begin
            step_strobe <= 1'b0;
        end
    end

    // 9-bit arithmetic: the carry catches overshoot, the sign bit catches underflow.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            sum_up[i]  = {1'b0, duty[i]} + {1'b0, step[i]};
            diff_dn[i] = {1'b0, duty[i]} - {1'b0, step[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state[i]  <= IDLE;
                duty[i]   <= '0;
                target[i] <= '0;
                step[i]   <= '0;
            end
            busy_r <= '0;
            done_r <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                done_r[i] <= 1'b0;
                if (load[i]) begin
                    // A load pre-empts any coincident step on this channel.
                    target[i] <= target_in[i];
                    step[i]   <= step_in[i];
                    if (target_in[i] > duty[i]) begin
                        state[i]  <= UP;
                        busy_r[i] <= 1'b1;
                    end else if (target_in[i] < duty[i]) begin
                        state[i]  <= DOWN;
                        busy_r[i] <= 1'b1;
                    end else begin
                        state[i]  <= IDLE;
                        busy_r[i] <= 1'b0;
                        done_r[i] <= 1'b1;
                    end
                end else if (step_strobe && fade_enable) begin
                    case (state[i])
                        UP: begin
                            if (step[i] == '0 || sum_up[i] >= {1'b0, target[i]}) begin
                                duty[i]   <= target[i];
                                state[i]  <= IDLE;
                                busy_r[i] <= 1'b0;
                                done_r[i] <= 1'b1;
                            end else begin
                                duty[i] <= sum_up[i][7:0];
                            end
                        end
                        DOWN: begin
                            if (step[i] == '0 ||
                                $signed(diff_dn[i]) <= $signed({1'b0, target[i]})) begin
                                duty[i]   <= target[i];
                                state[i]  <= IDLE;
                                busy_r[i] <= 1'b0;
                                done_r[i] <= 1'b1;
                            end else begin
                                duty[i] <= diff_dn[i][7:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign ch0_duty_cycle = duty[0];
    assign ch1_duty_cycle = duty[1];
    assign ch2_duty_cycle = duty[2];
    assign ch0_busy       = busy_r[0];
    assign ch1_busy       = busy_r[1];
    assign ch2_busy       = busy_r[2];
    assign ch0_done       = done_r[0];
    assign ch1_done       = done_r[1];
    assign ch2_done       = done_r[2];

`ifdef PWM_FADE_IRQ_EN
    logic [2:0] flags;
    logic [2:0] flags_next;

    // Set has priority over clear so a completion coinciding with a clear is not lost.
    always_comb begin
        flags_next = (irq_clear ? 3'b000 : flags) | done_r;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags <= '0;
            irq   <= 1'b0;
        end else begin
            flags <= flags_next;
            irq   <= |flags_next;
        end
    end
`else
    logic unused_irq_clear;
    assign unused_irq_clear = irq_clear;
    assign irq = 1'b0;
`endif

endmodule
